// File: rtl/hyper_rx_word_packer.sv
// hyper_rx_word_packer: RWDS-domain stage feeding the read CDC FIFO.
// Counts capture beats against the programmed burst length. In 8-bit memory
// mode it packs two 16-bit beats into one 32-bit word and pads an odd final
// beat. Overrun and extra-beat conditions are kept as sticky flags.
module hyper_rx_word_packer #(
   parameter int BEAT_CNT_W = 10,
   parameter int DATA_W     = 32
) (
   input  logic                  clk_rwds,
   input  logic                  resetReadModule,
   input  logic [1:0]            mem_sel_i,
   input  logic [BEAT_CNT_W-1:0] burst_len_i,
   input  logic                  beat_valid_i,
   input  logic [DATA_W-1:0]     beat_data_i,
   input  logic                  fifo_ready_i,
   output logic                  fifo_valid_o,
   output logic [DATA_W-1:0]     fifo_data_o,
   output logic                  fifo_last_o,
   output logic [BEAT_CNT_W-1:0] beat_cnt_o,
   output logic                  burst_done_o,
   output logic                  overrun_o,
   output logic                  extra_beat_o
);

   localparam int HALF_W = DATA_W / 2;

   typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic                    half_q, half_d;
   logic [HALF_W-1:0]       hold_q, hold_d;
   logic                    fifo_valid_q, fifo_valid_d;
   logic [DATA_W-1:0]       fifo_data_q, fifo_data_d;
   logic                    fifo_last_q, fifo_last_d;
   logic                    burst_done_q, burst_done_d;
   logic                    overrun_q, overrun_d;
   logic                    extra_beat_q, extra_beat_d;

   // One extra bit so the +1 at the saturated count never aliases a length.
   logic [BEAT_CNT_W:0]     cnt_p1;
   logic                    is_last;
   logic                    mode16;

   assign cnt_p1  = {1'b0, beat_cnt_q} + {{BEAT_CNT_W{1'b0}}, 1'b1};
   assign is_last = (burst_len_i != '0) && (cnt_p1 == {1'b0, burst_len_i});
   assign mode16  = (mem_sel_i == 2'b11);

   // Next-state: beat acceptance, packing and sticky flag updates.
   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      half_d       = half_q;
      hold_d       = hold_q;
      fifo_valid_d = 1'b0;
      fifo_data_d  = fifo_data_q;
      fifo_last_d  = 1'b0;
      burst_done_d = burst_done_q;
      overrun_d    = overrun_q;
      extra_beat_d = extra_beat_q;

      if (state_q == RUN) begin
         if (beat_valid_i) begin
            // Counter saturates; with burst_len 0 it simply parks at all-ones.
            beat_cnt_d = (&beat_cnt_q) ? beat_cnt_q : cnt_p1[BEAT_CNT_W-1:0];
            if (is_last) begin
               state_d      = DONE;
               burst_done_d = 1'b1;
            end
            if (mode16) begin
               fifo_data_d  = beat_data_i;
               fifo_valid_d = 1'b1;
               fifo_last_d  = is_last;
            end else if (!half_q) begin
               hold_d = beat_data_i[HALF_W-1:0];
               half_d = 1'b1;
               // Odd-length burst: flush the lone half, zero-padded on top.
               if (is_last) begin
                  fifo_data_d  = {{HALF_W{1'b0}}, beat_data_i[HALF_W-1:0]};
                  fifo_valid_d = 1'b1;
                  fifo_last_d  = 1'b1;
               end
            end else begin
               fifo_data_d  = {beat_data_i[HALF_W-1:0], hold_q};
               fifo_valid_d = 1'b1;
               fifo_last_d  = is_last;
               half_d       = 1'b0;
            end
         end
      end else begin
         if (beat_valid_i) extra_beat_d = 1'b1;
      end

      // RWDS cannot be stalled, so the word goes out anyway and we flag it.
      if (fifo_valid_d && !fifo_ready_i) overrun_d = 1'b1;
   end

   // State and output registers, cleared asynchronously by the read reset.
   always_ff @(posedge clk_rwds or posedge resetReadModule) begin
      if (resetReadModule) begin
         state_q      <= RUN;
         beat_cnt_q   <= '0;
         half_q       <= 1'b0;
         hold_q       <= '0;
         fifo_valid_q <= 1'b0;
         fifo_data_q  <= '0;
         fifo_last_q  <= 1'b0;
         burst_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         extra_beat_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         half_q       <= half_d;
         hold_q       <= hold_d;
         fifo_valid_q <= fifo_valid_d;
         fifo_data_q  <= fifo_data_d;
         fifo_last_q  <= fifo_last_d;
         burst_done_q <= burst_done_d;
         overrun_q    <= overrun_d;
         extra_beat_q <= extra_beat_d;
      end
   end

   assign fifo_valid_o = fifo_valid_q;
   assign fifo_data_o  = fifo_data_q;
   assign fifo_last_o  = fifo_last_q;
   assign beat_cnt_o   = beat_cnt_q;
   assign burst_done_o = burst_done_q;
   assign overrun_o    = overrun_q;
   assign extra_beat_o = extra_beat_q;

endmodule

// File: tb/tb_hyper_rx_word_packer.sv
// Directed bench for hyper_rx_word_packer: pass-through, packing, padding,
// extra beats, overrun and mid-burst reset.
module tb_hyper_rx_word_packer;

   logic        clk_rwds = 1'b0;
   logic        resetReadModule = 1'b1;
   logic [1:0]  mem_sel_i = 2'b11;
   logic [9:0]  burst_len_i = '0;
   logic        beat_valid_i = 1'b0;
   logic [31:0] beat_data_i = '0;
   logic        fifo_ready_i = 1'b1;
   logic        fifo_valid_o;
   logic [31:0] fifo_data_o;
   logic        fifo_last_o;
   logic [9:0]  beat_cnt_o;
   logic        burst_done_o;
   logic        overrun_o;
   logic        extra_beat_o;

   int checks = 0;
   int errors = 0;

   hyper_rx_word_packer #(.BEAT_CNT_W(10), .DATA_W(32)) dut (
      .clk_rwds        (clk_rwds),
      .resetReadModule (resetReadModule),
      .mem_sel_i       (mem_sel_i),
      .burst_len_i     (burst_len_i),
      .beat_valid_i    (beat_valid_i),
      .beat_data_i     (beat_data_i),
      .fifo_ready_i    (fifo_ready_i),
      .fifo_valid_o    (fifo_valid_o),
      .fifo_data_o     (fifo_data_o),
      .fifo_last_o     (fifo_last_o),
      .beat_cnt_o      (beat_cnt_o),
      .burst_done_o    (burst_done_o),
      .overrun_o       (overrun_o),
      .extra_beat_o    (extra_beat_o)
   );

   always #5 clk_rwds = ~clk_rwds;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one beat between edges, then sample just after the rising edge.
   task automatic beat(input logic v, input logic [31:0] d, input logic rdy);
      @(negedge clk_rwds);
      beat_valid_i = v;
      beat_data_i  = d;
      fifo_ready_i = rdy;
      @(posedge clk_rwds);
      #1;
   endtask

   // Reset pulse; outputs are checked before any clock edge to catch a sync clear.
   task automatic do_reset(input string tag);
      @(negedge clk_rwds);
      beat_valid_i    = 1'b0;
      fifo_ready_i    = 1'b1;
      resetReadModule = 1'b1;
      #1;
      chk({tag, "_flags"}, {27'd0, fifo_valid_o, fifo_last_o, burst_done_o, overrun_o, extra_beat_o}, 32'd0);
      chk({tag, "_data"}, fifo_data_o, 32'd0);
      chk({tag, "_cnt"}, {22'd0, beat_cnt_o}, 32'd0);
      @(posedge clk_rwds);
      @(negedge clk_rwds);
      resetReadModule = 1'b0;
   endtask

   initial begin
      logic [31:0] w16 [4];
      w16[0] = 32'h1111_2222; w16[1] = 32'h3333_4444;
      w16[2] = 32'h5555_6666; w16[3] = 32'h7777_8888;

      // Power-on reset.
      do_reset("por");

      // 16-bit pass-through, length 4.
      mem_sel_i = 2'b11; burst_len_i = 10'd4;
      for (int i = 0; i < 4; i++) begin
         beat(1'b1, w16[i], 1'b1);
         chk($sformatf("m16_valid%0d", i), {31'd0, fifo_valid_o}, 32'd1);
         chk($sformatf("m16_data%0d", i), fifo_data_o, w16[i]);
         chk($sformatf("m16_last%0d", i), {31'd0, fifo_last_o}, (i == 3) ? 32'd1 : 32'd0);
      end
      chk("m16_done", {31'd0, burst_done_o}, 32'd1);
      chk("m16_cnt", {22'd0, beat_cnt_o}, 32'd4);
      beat(1'b0, 32'h0, 1'b1);
      chk("m16_idle_valid", {31'd0, fifo_valid_o}, 32'd0);
      chk("m16_idle_data", fifo_data_o, 32'h7777_8888);

      // 8-bit packing, length 4; upper halves carry junk that must be ignored.
      do_reset("r1");
      mem_sel_i = 2'b00; burst_len_i = 10'd4;
      beat(1'b1, 32'hDEAD_A1A0, 1'b1);
      chk("p4_b1_valid", {31'd0, fifo_valid_o}, 32'd0);
      beat(1'b1, 32'hBEEF_B1B0, 1'b1);
      chk("p4_w1_valid", {31'd0, fifo_valid_o}, 32'd1);
      chk("p4_w1_data", fifo_data_o, 32'hB1B0_A1A0);
      chk("p4_w1_last", {31'd0, fifo_last_o}, 32'd0);
      beat(1'b1, 32'h1234_C1C0, 1'b1);
      chk("p4_b3_valid", {31'd0, fifo_valid_o}, 32'd0);
      chk("p4_b3_hold", fifo_data_o, 32'hB1B0_A1A0);
      beat(1'b1, 32'h5678_D1D0, 1'b1);
      chk("p4_w2_data", fifo_data_o, 32'hD1D0_C1C0);
      chk("p4_w2_last", {31'd0, fifo_last_o}, 32'd1);
      chk("p4_done", {31'd0, burst_done_o}, 32'd1);

      // 8-bit packing, odd length 3 with padding.
      do_reset("r2");
      mem_sel_i = 2'b01; burst_len_i = 10'd3;
      beat(1'b1, 32'h0000_A1A0, 1'b1);
      beat(1'b0, 32'hFFFF_FFFF, 1'b1);
      chk("p3_gap_valid", {31'd0, fifo_valid_o}, 32'd0);
      beat(1'b1, 32'h0000_B1B0, 1'b1);
      chk("p3_w1_data", fifo_data_o, 32'hB1B0_A1A0);
      beat(1'b1, 32'hFFFF_C1C0, 1'b1);
      chk("p3_w2_valid", {31'd0, fifo_valid_o}, 32'd1);
      chk("p3_w2_data", fifo_data_o, 32'h0000_C1C0);
      chk("p3_w2_last", {31'd0, fifo_last_o}, 32'd1);
      chk("p3_overrun", {31'd0, overrun_o}, 32'd0);
      chk("p3_cnt", {22'd0, beat_cnt_o}, 32'd3);

      // 16-bit, length 2, then 3 extra beats.
      do_reset("r3");
      mem_sel_i = 2'b11; burst_len_i = 10'd2;
      beat(1'b1, 32'hAAAA_0001, 1'b1);
      beat(1'b1, 32'hAAAA_0002, 1'b1);
      chk("x_w2_last", {31'd0, fifo_last_o}, 32'd1);
      chk("x_extra_pre", {31'd0, extra_beat_o}, 32'd0);
      beat(1'b1, 32'hAAAA_0003, 1'b1);
      chk("x_e1_valid", {31'd0, fifo_valid_o}, 32'd0);
      chk("x_e1_extra", {31'd0, extra_beat_o}, 32'd1);
      beat(1'b1, 32'hAAAA_0004, 1'b1);
      beat(1'b1, 32'hAAAA_0005, 1'b1);
      chk("x_valid", {31'd0, fifo_valid_o}, 32'd0);
      chk("x_data", fifo_data_o, 32'hAAAA_0002);
      chk("x_cnt", {22'd0, beat_cnt_o}, 32'd2);
      chk("x_extra", {31'd0, extra_beat_o}, 32'd1);

      // Overrun on 2nd beat, unlimited length: stays in RUN, flag sticky.
      do_reset("r4");
      mem_sel_i = 2'b11; burst_len_i = 10'd0;
      beat(1'b1, 32'hCAFE_0001, 1'b1);
      chk("o_b1_overrun", {31'd0, overrun_o}, 32'd0);
      beat(1'b1, 32'hCAFE_0002, 1'b0);
      chk("o_b2_valid", {31'd0, fifo_valid_o}, 32'd1);
      chk("o_b2_data", fifo_data_o, 32'hCAFE_0002);
      chk("o_b2_overrun", {31'd0, overrun_o}, 32'd1);
      beat(1'b1, 32'hCAFE_0003, 1'b1);
      beat(1'b0, 32'h0, 1'b1);
      chk("o_sticky", {31'd0, overrun_o}, 32'd1);
      chk("o_not_done", {31'd0, burst_done_o}, 32'd0);
      chk("o_cnt", {22'd0, beat_cnt_o}, 32'd3);
      // An idle edge with ready low must not set the flag: checked after a reset.
      do_reset("r5");
      beat(1'b0, 32'h0, 1'b0);
      chk("o_idle_noflag", {31'd0, overrun_o}, 32'd0);

      // 8-bit, reset after one beat discards the held half.
      mem_sel_i = 2'b00; burst_len_i = 10'd2;
      beat(1'b1, 32'h0000_E1E0, 1'b1);
      chk("rr_pre_cnt", {22'd0, beat_cnt_o}, 32'd1);
      do_reset("rr_mid");
      beat(1'b1, 32'h0000_F1F0, 1'b1);
      chk("rr_b1_valid", {31'd0, fifo_valid_o}, 32'd0);
      beat(1'b1, 32'h0000_0A0B, 1'b1);
      chk("rr_w_valid", {31'd0, fifo_valid_o}, 32'd1);
      chk("rr_w_data", fifo_data_o, 32'h0A0B_F1F0);
      chk("rr_w_last", {31'd0, fifo_last_o}, 32'd1);
      chk("rr_cnt", {22'd0, beat_cnt_o}, 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
